// File: rtl/npu_mem_reader_if.sv
// npu_mem_reader_if: command/status and beat stream between the read engine and its controller/consumer.
interface npu_mem_reader_if;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    modport master (
        output start, mode, base_addr, length, out_ready,
        input  busy, done, out_data, out_valid, out_last
    );
    modport slave (
        input  start, mode, base_addr, length, out_ready,
        output busy, done, out_data, out_valid, out_last
    );
endinterface

// File: rtl/npu_mem_reader.sv
// npu_mem_reader: burst reader over image/conv/dense RAMs (1-cycle read latency) feeding a valid/ready beat stream.
module npu_mem_reader #(
    parameter int FIFO_DEPTH = 2,
    parameter int IMG_AW     = 14,
    parameter int WGT_AW     = 16
) (
    input  logic              clk,
    input  logic              reset,
    npu_mem_reader_if.slave   bus,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [7:0]        img_q0,
    input  logic [7:0]        img_q1,
    input  logic [7:0]        img_q2,
    input  logic [7:0]        img_q3,
    output logic [WGT_AW-1:0] conv_addr,
    input  logic [7:0]        conv_q,
    output logic [WGT_AW-1:0] dense_addr,
    input  logic [7:0]        dense_q
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = PW + 2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    state_t          state, state_nx;
    logic [1:0]      mode_r;
    logic [15:0]     len_r;
    logic [15:0]     issued;
    logic [31:0]     fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            inflight, inflight_last;
    logic            cmd_ok, load, issue, issue_last, pop;
    logic [31:0]     q_data;

    assign cmd_ok     = bus.length != 16'd0 && bus.mode != 2'b11;
    assign load       = state == IDLE && bus.start && cmd_ok;
    assign issue_last = issued == len_r - 16'd1;
    assign pop        = |count && bus.out_ready;
    // A slot freed by this cycle's pop is reusable: the new read lands two edges later.
    assign issue      = state == FETCH && issued < len_r &&
                        ({1'b0, count} + OW'(inflight)) < (OW'(FIFO_DEPTH) + OW'(pop));
    assign q_data     = mode_r == 2'b00 ? {img_q0, img_q1, img_q2, img_q3}
                                        : {24'h0, mode_r == 2'b01 ? conv_q : dense_q};

    assign bus.busy      = state == FETCH || state == DRAIN;
    assign bus.done      = state == FINISH;
    assign bus.out_valid = |count;
    assign bus.out_data  = fifo_data[rd_ptr];
    assign bus.out_last  = |count && fifo_last[rd_ptr];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? (cmd_ok ? FETCH : FINISH) : IDLE;
            FETCH:   state_nx = issue && issue_last ? DRAIN : FETCH;
            DRAIN:   state_nx = pop && fifo_last[rd_ptr] ? FINISH : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            mode_r        <= 2'b00;
            len_r         <= 16'd0;
            issued        <= 16'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            img_addr      <= '0;
            conv_addr     <= '0;
            dense_addr    <= '0;
            fifo_last     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
        end else begin
            state         <= state_nx;
            inflight      <= issue;
            inflight_last <= issue && issue_last;
            if (load) begin
                mode_r     <= bus.mode;
                len_r      <= bus.length;
                issued     <= 16'd0;
                img_addr   <= bus.mode == 2'b00 ? IMG_AW'(bus.base_addr) : img_addr;
                conv_addr  <= bus.mode == 2'b01 ? WGT_AW'(bus.base_addr) : conv_addr;
                dense_addr <= bus.mode == 2'b10 ? WGT_AW'(bus.base_addr) : dense_addr;
            end
            if (issue) begin
                issued     <= issued + 16'd1;
                img_addr   <= mode_r == 2'b00 ? img_addr + IMG_AW'(1) : img_addr;
                conv_addr  <= mode_r == 2'b01 ? conv_addr + WGT_AW'(1) : conv_addr;
                dense_addr <= mode_r == 2'b10 ? dense_addr + WGT_AW'(1) : dense_addr;
            end
            if (inflight) begin
                fifo_data[wr_ptr] <= q_data;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(inflight) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_npu_mem_reader.sv
// tb_npu_mem_reader: scoreboard bench; driver queues expected beats from a RAM-content model, monitor checks the stream.
module tb_npu_mem_reader;
    localparam int DEPTH = 2;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] img_addr;
    logic [7:0]  img_q0, img_q1, img_q2, img_q3, conv_q, dense_q;
    logic [15:0] conv_addr, dense_addr;
    logic [7:0]  img_m0 [16384];
    logic [7:0]  img_m1 [16384];
    logic [7:0]  img_m2 [16384];
    logic [7:0]  img_m3 [16384];
    logic [7:0]  conv_m [65536];
    logic [7:0]  dense_m [65536];

    beat_t       exp_q [$];
    int          hs_cyc [$];
    logic [13:0] addr_q [$];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, hs_total = 0, done_cnt = 0, done_cyc = 0;
    int cmd_hs0 = 0, done0 = 0, max_out = 0, o;
    int ready_mode = 0;
    logic [15:0] cmd_base = 16'h0;
    logic log_addr = 1'b0, track_out = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    npu_mem_reader_if bus();

    npu_mem_reader #(.FIFO_DEPTH(DEPTH), .IMG_AW(14), .WGT_AW(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .img_addr(img_addr), .img_q0(img_q0), .img_q1(img_q1), .img_q2(img_q2), .img_q3(img_q3),
        .conv_addr(conv_addr), .conv_q(conv_q), .dense_addr(dense_addr), .dense_q(dense_q)
    );

    always @(posedge clk) begin
        img_q0  <= img_m0[img_addr];
        img_q1  <= img_m1[img_addr];
        img_q2  <= img_m2[img_addr];
        img_q3  <= img_m3[img_addr];
        conv_q  <= conv_m[conv_addr];
        dense_q <= dense_m[dense_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t ref_beat(input logic [1:0] m, input logic [15:0] b, input int k, input int l);
        beat_t r;
        logic [15:0] a;
        a = b + 16'(k);
        r.l = (k == l - 1);
        case (m)
            2'b00:   r.d = {img_m0[a[13:0]], img_m1[a[13:0]], img_m2[a[13:0]], img_m3[a[13:0]]};
            2'b01:   r.d = {24'h0, conv_m[a]};
            default: r.d = {24'h0, dense_m[a]};
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (log_addr && bus.busy && (addr_q.size() == 0 || addr_q[$] != img_addr))
                addr_q.push_back(img_addr);
            if (track_out && bus.busy) begin
                o = int'(conv_addr - cmd_base) - (hs_total - cmd_hs0);
                if (o > max_out) max_out = o;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected beat: got %h, expected no beat", bus.out_data);
                end else begin
                    chk("beat data", bus.out_data, exp_q[0].d);
                    chk("beat last", 32'(bus.out_last), 32'(exp_q[0].l));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
                if (bus.out_ready) begin
                    hs_total++;
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = $urandom_range(0, 9) < 7;
            endcase
        end
    end

    task automatic raw_start(input logic [1:0] m, input logic [15:0] b, input logic [15:0] l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode = m;
        bus.base_addr = b;
        bus.length = l;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic issue_cmd(input logic [1:0] m, input logic [15:0] b, input logic [15:0] l);
        if (l != 16'd0 && m != 2'b11)
            for (int k = 0; k < int'(l); k++) exp_q.push_back(ref_beat(m, b, k, int'(l)));
        cmd_base = b;
        cmd_hs0 = hs_total;
        done0 = done_cnt;
        hs_cyc.delete();
        raw_start(m, b, l);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((bus.busy || bus.done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: still busy after %0d cycles, expected idle", name, budget);
        end
        @(negedge clk);
        chk({name, " done pulses"}, 32'(done_cnt - done0), 32'd1);
        chk({name, " leftover beats"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_total < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake wait: got %0d beats, expected %0d", hs_total, target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 16384; k++) begin
            img_m0[k] = 8'(k);
            img_m1[k] = 8'(k + 1);
            img_m2[k] = 8'(k + 2);
            img_m3[k] = 8'(k + 3);
        end
        for (int k = 0; k < 65536; k++) begin
            conv_m[k]  = 8'($urandom);
            dense_m[k] = 8'($urandom);
        end
        bus.start = 1'b0;
        bus.mode = 2'b00;
        bus.base_addr = 16'h0;
        bus.length = 16'h0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset valid", 32'(bus.out_valid), 32'd0);
        chk("reset data", bus.out_data, 32'h0);
        chk("reset img_addr", 32'(img_addr), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // image burst, latency and back-to-back beats
        ready_mode = 0;
        issue_cmd(2'b00, 16'h0010, 16'd4);
        chk("latency T+0 valid", 32'(bus.out_valid), 32'd0);
        chk("busy after start", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk("latency T+1 valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        chk("latency T+2 valid", 32'(bus.out_valid), 32'd1);
        chk("first image beat", bus.out_data, 32'h10111213);
        wait_idle("image", 100);
        chk("image beat count", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() == 4) begin
            chk("image beats consecutive", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);
            chk("image done after last", 32'(done_cyc), 32'(hs_cyc[3] + 1));
        end

        // conv with alternating backpressure
        for (int i = 0; i < 8; i++) conv_m[16'h0100 + i] = 8'(i);
        ready_mode = 1;
        track_out = 1'b1;
        max_out = 0;
        issue_cmd(2'b01, 16'h0100, 16'd8);
        wait_idle("conv backpressure", 200);
        track_out = 1'b0;
        chk("conv beat count", 32'(hs_total - cmd_hs0), 32'd8);
        chk("outstanding within depth", 32'(max_out <= DEPTH), 32'd1);

        // zero length and reserved mode
        ready_mode = 0;
        issue_cmd(2'b00, 16'h0000, 16'd0);
        chk("len0 busy", 32'(bus.busy), 32'd0);
        chk("len0 done", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
        chk("len0 done drops", 32'(bus.done), 32'd0);
        wait_idle("len0", 20);
        issue_cmd(2'b11, 16'h0040, 16'd5);
        chk("mode3 busy", 32'(bus.busy), 32'd0);
        chk("mode3 done", 32'(bus.done), 32'd1);
        wait_idle("mode3", 20);
        chk("mode3 no beats", 32'(hs_total - cmd_hs0), 32'd0);

        // image address wrap
        addr_q.delete();
        log_addr = 1'b1;
        issue_cmd(2'b00, 16'h3FFE, 16'd4);
        wait_idle("wrap", 100);
        log_addr = 1'b0;
        chk("wrap addr count", 32'(addr_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < addr_q.size()) chk("wrap addr", 32'(addr_q[i]), 32'((16'h3FFE + 16'(i)) & 16'h3FFF));

        // start while busy is ignored
        issue_cmd(2'b10, 16'hFFFE, 16'd5);
        wait_hs(cmd_hs0 + 2, 50);
        raw_start(2'b10, 16'h0000, 16'd3);
        wait_idle("start while busy", 100);
        chk("busy start beat count", 32'(hs_total - cmd_hs0), 32'd5);

        // asynchronous reset mid-burst
        issue_cmd(2'b00, 16'h0200, 16'd10);
        wait_hs(cmd_hs0 + 2, 50);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort valid", 32'(bus.out_valid), 32'd0);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        exp_q.delete();
        done0 = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort no done", 32'(done_cnt - done0), 32'd0);
        issue_cmd(2'b01, 16'h0010, 16'd2);
        wait_idle("after abort", 50);
        chk("after abort beats", 32'(hs_total - cmd_hs0), 32'd2);

        // randomized commands with random backpressure
        ready_mode = 2;
        for (int t = 0; t < 20; t++) begin
            logic [1:0]  m;
            logic [15:0] b, l;
            m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'(($urandom_range(0, 2)));
            b = 16'($urandom);
            l = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            issue_cmd(m, b, l);
            wait_idle("random", 300);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
